// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register-file write-back arbiter.
//   DATA_W / ADDR_W : write data and register address widths
//   NUM_LANES       : execution lanes feeding the arbiter
//   wb_req_t        : one write-back request {addr, data}
package regfile_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned NUM_REGS  = 1 << ADDR_W;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = $clog2(NUM_LANES);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Round-robin successor; wraps naturally because NUM_LANES is a power of two.
  function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] lane);
    return lane + LANE_W'(1);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the execution lanes, the write-back arbiter and the register
// file write port 0.
//   master : lane side (drives wbValid/wbAddrN/wbDataN, sees wbReady,
//            rfWrite* and pending)
//   slave  : arbiter side (the reverse)
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic [NUM_LANES-1:0] wbValid;
  logic [ADDR_W-1:0]    wbAddr0;
  logic [ADDR_W-1:0]    wbAddr1;
  logic [ADDR_W-1:0]    wbAddr2;
  logic [ADDR_W-1:0]    wbAddr3;
  logic [DATA_W-1:0]    wbData0;
  logic [DATA_W-1:0]    wbData1;
  logic [DATA_W-1:0]    wbData2;
  logic [DATA_W-1:0]    wbData3;
  logic [NUM_LANES-1:0] wbReady;
  logic                 rfWriteEnable;
  logic [ADDR_W-1:0]    rfWriteAddr;
  logic [DATA_W-1:0]    rfWriteData;
  logic [NUM_REGS-1:0]  pending;

  modport master (
    output wbValid, wbAddr0, wbAddr1, wbAddr2, wbAddr3,
           wbData0, wbData1, wbData2, wbData3,
    input  wbReady, rfWriteEnable, rfWriteAddr, rfWriteData, pending
  );

  modport slave (
    input  wbValid, wbAddr0, wbAddr1, wbAddr2, wbAddr3,
           wbData0, wbData1, wbData2, wbData3,
    output wbReady, rfWriteEnable, rfWriteAddr, rfWriteData, pending
  );

endinterface

// File: rtl/wb_lane_fifo.sv
// Per-lane write-back FIFO: circular buffer with occupancy count, plus a view
// of which slots hold live entries and their addresses for the pending mask.
//   clk, rst     : clock, async active-high reset
//   push/push_req: enqueue one request (caller guarantees not full)
//   pop          : dequeue head (caller guarantees not empty)
//   head         : oldest entry
//   empty, count : occupancy
//   entry_valid  : slot i holds a queued entry
//   entry_addr   : address stored in slot i
module wb_lane_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wb_req_t                          push_req,
  input  logic                             pop,
  output wb_req_t                          head,
  output logic                             empty,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]     entry_addr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] off;

  // Storage is not reset; validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
      entry_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: four lane FIFOs drained round-robin into a single
// registered write to register-file port 0, plus a pending-register mask.
//   clk, rst : clock, async active-high reset
//   bus      : regfile_wb_arbiter_if.slave (lane handshakes, rf write, pending)
// Optional feature macro: REGFILE_WB_ZERO_REG_EN -- writes to register 0 are
// acknowledged but dropped, and pending[0] is held low.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_req_t [NUM_LANES-1:0]                              push_req;
  wb_req_t [NUM_LANES-1:0]                              head;
  logic    [NUM_LANES-1:0]                              ready;
  logic    [NUM_LANES-1:0]                              push;
  logic    [NUM_LANES-1:0]                              pop;
  logic    [NUM_LANES-1:0]                              empty;
  logic    [NUM_LANES-1:0][CNT_W-1:0]                   count;
  logic    [NUM_LANES-1:0][FIFO_DEPTH-1:0]              entry_valid;
  logic    [NUM_LANES-1:0][FIFO_DEPTH-1:0][ADDR_W-1:0]  entry_addr;

  logic [LANE_W-1:0]   rr_ptr;
  logic [LANE_W-1:0]   grant_lane;
  logic                grant_valid;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_REGS-1:0] pend;

  assign push_req[0] = {bus.wbAddr0, bus.wbData0};
  assign push_req[1] = {bus.wbAddr1, bus.wbData1};
  assign push_req[2] = {bus.wbAddr2, bus.wbData2};
  assign push_req[3] = {bus.wbAddr3, bus.wbData3};

  // Ready comes from registered occupancy only; a pop this cycle does not help.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      ready[k] = (count[k] < CNT_W'(FIFO_DEPTH));
      push[k]  = bus.wbValid[k] && ready[k];
`ifdef REGFILE_WB_ZERO_REG_EN
      if (push_req[k].addr == '0) push[k] = 1'b0;
`endif
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    wb_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push[k]),
      .push_req    (push_req[k]),
      .pop         (pop[k]),
      .head        (head[k]),
      .empty       (empty[k]),
      .count       (count[k]),
      .entry_valid (entry_valid[k]),
      .entry_addr  (entry_addr[k])
    );
  end

  // First non-empty lane at or above the round-robin pointer (mod NUM_LANES).
  always_comb begin
    grant_valid = 1'b0;
    grant_lane  = rr_ptr;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!grant_valid && !empty[rr_ptr + LANE_W'(i)]) begin
        grant_valid = 1'b1;
        grant_lane  = rr_ptr + LANE_W'(i);
      end
    end
    for (int k = 0; k < NUM_LANES; k++) begin
      pop[k] = grant_valid && (grant_lane == LANE_W'(k));
    end
  end

  // Round-robin pointer and registered write port; addr/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= grant_valid;
      if (grant_valid) begin
        rr_ptr  <= next_lane(grant_lane);
        wr_addr <= head[grant_lane].addr;
        wr_data <= head[grant_lane].data;
      end
    end
  end

  // Every queued entry plus the write currently on the port marks its register.
  always_comb begin
    pend = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        if (entry_valid[k][e]) pend[entry_addr[k][e]] = 1'b1;
      end
    end
    if (wr_en) pend[wr_addr] = 1'b1;
`ifdef REGFILE_WB_ZERO_REG_EN
    pend[0] = 1'b0;
`endif
  end

  assign bus.wbReady       = ready;
  assign bus.rfWriteEnable = wr_en;
  assign bus.rfWriteAddr   = wr_addr;
  assign bus.rfWriteData   = wr_data;
  assign bus.pending       = pend;

endmodule
